rtc_display_update_sched: RTL and testbench



---
 rtl/rtc_display_update_sched_pkg.sv | 44 ++++
 rtl/rtc_display_update_sched_if.sv | 26 ++
 rtl/rtc_display_update_sched_fifo.sv | 52 +++++
 rtl/rtc_display_update_sched.sv | 142 ++++++++++++++
 tb/tb_rtc_display_update_sched.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_display_update_sched_pkg.sv
// Shared constants, register indices, FSM encoding and the staged-entry
// format for the RTC display update scheduler. The optional discard
// counter is enabled by defining SCHED_DROP_CNT_EN.
package rtc_display_update_sched_pkg;

  // Frame geometry of the 640x480 sync generator (lines)
  localparam int VM      = 480;
  localparam int V_TOTAL = 525;

  // Shadow bank geometry
  localparam int NREG  = 9;
  localparam int DEPTH = 4;

  // Shadow register indices
  localparam logic [3:0] REG_SEC      = 4'd0;
  localparam logic [3:0] REG_MIN      = 4'd1;
  localparam logic [3:0] REG_HOUR     = 4'd2;
  localparam logic [3:0] REG_DAY      = 4'd3;
  localparam logic [3:0] REG_MONTH    = 4'd4;
  localparam logic [3:0] REG_YEAR     = 4'd5;
  localparam logic [3:0] REG_TMR_SEC  = 4'd6;
  localparam logic [3:0] REG_TMR_MIN  = 4'd7;
  localparam logic [3:0] REG_TMR_HOUR = 4'd8;

  // Commit scheduler states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_e;

  // One staged update: register index plus BCD value (12 bits)
  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } sched_entry_t;

  // True when an index names a real shadow register
  function automatic logic addr_valid(input logic [3:0] a);
    return a < 4'(NREG);
  endfunction

endpackage

// File: rtl/rtc_display_update_sched_if.sv
// Bus between the RTC read/write FSM, the pixel generator and the scheduler.
//
// Write handshake: the requester raises wr_req with wr_addr/wr_data stable
// and holds them until wr_ack. wr_ack is a one-cycle pulse and the entry is
// captured on the clock edge that ends the ack cycle. A wr_req still high in
// the cycle after the ack is treated as a fresh request. Without space the
// request simply waits; nothing is dropped.
// Read port: rd_data is a combinational view of shadow[rd_addr].
interface rtc_display_update_sched_if;
  logic       wr_req;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output wr_req, wr_addr, wr_data, rd_addr,
    input  wr_ack, rd_data
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_addr,
    output wr_ack, rd_data
  );
endinterface

// File: rtl/rtc_display_update_sched_fifo.sv
// Staging FIFO for pending shadow updates. Show-ahead: dout is the head
// entry whenever the FIFO is not empty. A push while full is accepted only
// together with a pop in the same cycle (the caller guarantees this).
module sched_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage array; contents need no reset because count gates validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap modulo DEPTH; occupancy kept in a separate counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rtc_display_update_sched.sv
// RTC display update scheduler. Updates from the RTC side are staged in a
// small FIFO and committed to the shadow bank only during vertical blanking,
// so the pixel generator never draws a frame with mixed old/new digits.
// Optional: define SCHED_DROP_CNT_EN to add drop_cnt, a saturating count of
// entries discarded at commit for an out-of-range register index.
module rtc_display_update_sched
  import rtc_display_update_sched_pkg::*;
(
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [9:0]                        pixel_Y,
  rtc_display_update_sched_if.slave         bus,
  output logic                              in_vblank,
  output logic                              commit_done,
  output logic [2:0]                        pending,
  output sched_state_e                      state_dbg
`ifdef SCHED_DROP_CNT_EN
  ,
  output logic [7:0]                        drop_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_e  state_q;
  sched_state_e  state_d;
  logic          in_vblank_q;
  logic          ack_prev_q;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [11:0]   fifo_dout;
  sched_entry_t  head;
  sched_entry_t  wr_entry;
  logic [7:0]    shadow [NREG];

  assign wr_entry.addr = bus.wr_addr;
  assign wr_entry.data = bus.wr_data;
  assign head          = sched_entry_t'(fifo_dout);

  // Pop one entry per cycle while committing inside the blank
  assign pop = (state_q == ST_COMMIT) && in_vblank_q && !fifo_empty;

  // Accept when space exists, or when the head leaves in the same cycle;
  // the previous-cycle ack keeps each accept to a single-cycle pulse
  assign push       = bus.wr_req && !ack_prev_q && (!fifo_full || pop);
  assign bus.wr_ack = push;

  assign in_vblank = in_vblank_q;
  assign pending   = 3'(fifo_count);
  assign state_dbg = state_q;

  sched_fifo #(
    .DEPTH (DEPTH),
    .W     (12)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Registered blanking qualifier and ack history
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_vblank_q <= 1'b0;
      ack_prev_q  <= 1'b0;
    end else begin
      in_vblank_q <= (pixel_Y >= 10'(VM));
      ack_prev_q  <= push;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and commit_done pulse
  always_comb begin
    state_d     = state_q;
    commit_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_count != '0) state_d = in_vblank_q ? ST_COMMIT : ST_WAIT;
      end
      ST_WAIT: begin
        if (in_vblank_q) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        // Blank ended (or nothing to pop): stop; leftovers wait a frame.
        // Last entry popped with no refill: burst finished.
        if (!pop)                                      state_d = ST_DONE;
        else if (fifo_count == CW'(1) && !push)        state_d = ST_DONE;
      end
      ST_DONE: begin
        commit_done = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow bank update; out-of-range indices match no register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) shadow[i] <= 8'h00;
    end else if (pop) begin
      for (int i = 0; i < NREG; i++) begin
        if (head.addr == 4'(i)) shadow[i] <= head.data;
      end
    end
  end

  // Read mux for the pixel generator; 0 beyond the bank
  always_comb begin
    bus.rd_data = 8'h00;
    for (int i = 0; i < NREG; i++) begin
      if (bus.rd_addr == 4'(i)) bus.rd_data = shadow[i];
    end
  end

`ifdef SCHED_DROP_CNT_EN
  // Saturating count of entries discarded for an invalid index
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drop_cnt <= 8'd0;
    end else if (pop && !addr_valid(head.addr) && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rtc_display_update_sched.sv
// Directed bench for rtc_display_update_sched: table-driven pushes and
// shadow read-back, plus hand-written multi-cycle sequences for deferred
// commit, back-pressure, blank-time arrival, blank ending mid-burst and
// reset in the middle of a commit burst.
module tb_rtc_display_update_sched;
  import rtc_display_update_sched_pkg::*;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } push_vec_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [9:0]   pixel_Y;
  logic         in_vblank;
  logic         commit_done;
  logic [2:0]   pending;
  sched_state_e state_dbg;
`ifdef SCHED_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  rtc_display_update_sched_if bus ();

  rtc_display_update_sched dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .pixel_Y     (pixel_Y),
    .bus         (bus),
    .in_vblank   (in_vblank),
    .commit_done (commit_done),
    .pending     (pending),
    .state_dbg   (state_dbg)
`ifdef SCHED_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  // Clock: 100 MHz
  always #5 CLK = ~CLK;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    bus.rd_addr = a;
    #1;
    check(name, {24'd0, bus.rd_data}, {24'd0, exp});
  endtask

  // Hold a request until acked (bounded), then drop it at the next negedge
  task automatic push(input logic [3:0] a, input logic [7:0] d);
    bit acked;
    acked       = 1'b0;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    for (int i = 0; i < 32 && !acked; i++) begin
      #1;
      if (bus.wr_ack) acked = 1'b1;
      @(negedge CLK);
    end
    bus.wr_req = 1'b0;
    check("push_ack", {31'd0, acked}, 32'd1);
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      #1;
      if (commit_done) pulses++;
      @(negedge CLK);
    end
  endtask

  push_vec_t pv [4];
  rd_vec_t   rv [16];
  int        pulses;

  initial begin
    // Stimulus tables
    pv[0] = '{REG_HOUR,     8'h11};
    pv[1] = '{REG_HOUR,     8'h23};
    pv[2] = '{4'd12,        8'hAA};
    pv[3] = '{REG_TMR_HOUR, 8'h42};

    rv[0] = '{REG_SEC,      8'h59};
    rv[1] = '{REG_MIN,      8'h07};
    rv[2] = '{REG_HOUR,     8'h23};
    rv[3] = '{REG_DAY,      8'h33};
    rv[4] = '{REG_MONTH,    8'h42};
    rv[5] = '{REG_YEAR,     8'h15};
    rv[6] = '{REG_TMR_SEC,  8'h16};
    rv[7] = '{REG_TMR_MIN,  8'h17};
    rv[8] = '{REG_TMR_HOUR, 8'h42};
    for (int i = 9; i < 16; i++) rv[i] = '{4'(i), 8'h00};

    // Reset mid-frame
    RESET       = 1'b1;
    pixel_Y     = 10'd200;
    bus.wr_req  = 1'b0;
    bus.wr_addr = 4'd0;
    bus.wr_data = 8'd0;
    bus.rd_addr = 4'd0;
    step(2);
    for (int i = 0; i < 16; i++) rd_chk("rst_rd", 4'(i), 8'h00);
    check("rst_pending",   32'(pending),     32'd0);
    check("rst_wr_ack",    32'(bus.wr_ack),  32'd0);
    check("rst_done",      32'(commit_done), 32'd0);
    check("rst_vblank",    32'(in_vblank),   32'd0);
    check("rst_state",     32'(state_dbg),   32'(ST_IDLE));
`ifdef SCHED_DROP_CNT_EN
    check("rst_drop_cnt",  32'(drop_cnt),    32'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;

    // in_vblank follows pixel_Y
    step(1);
    check("vb_active", 32'(in_vblank), 32'd0);
    pixel_Y = 10'(V_TOTAL - 25);
    step(1);
    check("vb_blank", 32'(in_vblank), 32'd1);
    pixel_Y = 10'd479;
    step(1);
    check("vb_last_line", 32'(in_vblank), 32'd0);

    // Deferred commit
    pixel_Y = 10'd100;
    @(negedge CLK);
    push(REG_SEC, 8'h59);
    check("def_pending", 32'(pending), 32'd1);
    step(1);
    check("def_wait", 32'(state_dbg), 32'(ST_WAIT));
    pixel_Y = 10'd479;
    step(3);
    rd_chk("def_hold_479", REG_SEC, 8'h00);
    @(negedge CLK);
    pixel_Y = 10'd480;
    step(1);
    rd_chk("def_lat1", REG_SEC, 8'h00);
    step(1);
    rd_chk("def_lat2", REG_SEC, 8'h00);
    step(1);
    rd_chk("def_commit", REG_SEC, 8'h59);
    check("def_done_pulse", 32'(commit_done), 32'd1);
    step(1);
    check("def_done_low", 32'(commit_done), 32'd0);
    check("def_idle", 32'(state_dbg), 32'(ST_IDLE));

    // Back-pressure: four fill the FIFO, the fifth waits for the first pop
    pixel_Y = 10'd100;
    step(2);
    push(REG_DAY,   8'h31);
    push(REG_MONTH, 8'h41);
    push(REG_DAY,   8'h32);
    push(REG_MONTH, 8'h42);
    check("bp_pending_full", 32'(pending), 32'd4);
    bus.wr_addr = REG_DAY;
    bus.wr_data = 8'h33;
    bus.wr_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_hold", 32'(bus.wr_ack), 32'd0);
      @(negedge CLK);
    end
    check("bp_pending_held", 32'(pending), 32'd4);
    pixel_Y = 10'd480;
    step(1);
    #1;
    check("bp_no_ack_wait", 32'(bus.wr_ack), 32'd0);
    step(1);
    #1;
    check("bp_ack_on_pop", 32'(bus.wr_ack), 32'd1);
    check("bp_commit", 32'(state_dbg), 32'(ST_COMMIT));
    step(1);
    bus.wr_req = 1'b0;
    count_done(12, pulses);
    check("bp_done_pulses", 32'(pulses), 32'd1);
    check("bp_pending_end", 32'(pending), 32'd0);
    rd_chk("bp_order_day",   REG_DAY,   8'h33);
    rd_chk("bp_order_month", REG_MONTH, 8'h42);

    // Table pushes: last-write-wins and invalid index
    pixel_Y = 10'd100;
    step(2);
    for (int i = 0; i < 4; i++) push(pv[i].addr, pv[i].data);
    check("tbl_pending", 32'(pending), 32'd4);
    pixel_Y = 10'd480;
    count_done(12, pulses);
    check("tbl_done_pulses", 32'(pulses), 32'd1);
    rd_chk("tbl_lww",     REG_HOUR, 8'h23);
    rd_chk("tbl_invalid", 4'd12,    8'h00);
`ifdef SCHED_DROP_CNT_EN
    check("tbl_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Arrival during blank goes straight to COMMIT
    pixel_Y = 10'd490;
    step(1);
    push(REG_MIN, 8'h07);
    step(1);
    check("blank_direct", 32'(state_dbg), 32'(ST_COMMIT));
    step(1);
    rd_chk("blank_commit", REG_MIN, 8'h07);
    check("blank_pending", 32'(pending), 32'd0);

    // Blank ends after one pop: leftovers wait for the next frame
    pixel_Y = 10'd0;
    step(3);
    push(REG_YEAR,    8'h15);
    push(REG_TMR_SEC, 8'h16);
    push(REG_TMR_MIN, 8'h17);
    pixel_Y = 10'd480;
    step(2);
    check("fall_commit", 32'(state_dbg), 32'(ST_COMMIT));
    pixel_Y = 10'd0;
    step(1);
    rd_chk("fall_first", REG_YEAR, 8'h15);
    step(1);
    check("fall_done", 32'(commit_done), 32'd1);
    check("fall_pending", 32'(pending), 32'd2);
    rd_chk("fall_deferred", REG_TMR_SEC, 8'h00);
    step(2);
    check("fall_rewait", 32'(state_dbg), 32'(ST_WAIT));
    pixel_Y = 10'd480;
    count_done(10, pulses);
    check("fall_done_pulses", 32'(pulses), 32'd1);
    check("fall_pending_end", 32'(pending), 32'd0);

    // Full bank read-back
    for (int i = 0; i < 16; i++) rd_chk("bank_rd", rv[i].addr, rv[i].exp);

    // Reset on the second commit cycle
    pixel_Y = 10'd100;
    step(2);
    for (int i = 0; i < 4; i++) push(4'(i), 8'hC0 + 8'(i));
    check("rmc_pending", 32'(pending), 32'd4);
    pixel_Y = 10'd480;
    step(2);
    check("rmc_commit1", 32'(state_dbg), 32'(ST_COMMIT));
    step(1);
    rd_chk("rmc_partial", REG_SEC, 8'hC0);
    check("rmc_commit2", 32'(state_dbg), 32'(ST_COMMIT));
    RESET = 1'b1;
    #1;
    for (int i = 0; i < NREG; i++) rd_chk("rmc_rd", 4'(i), 8'h00);
    check("rmc_pending0", 32'(pending),     32'd0);
    check("rmc_idle",     32'(state_dbg),   32'(ST_IDLE));
    check("rmc_no_done",  32'(commit_done), 32'd0);
    step(2);
    RESET = 1'b0;
    count_done(6, pulses);
    check("rmc_done_pulses", 32'(pulses),    32'd0);
    check("rmc_idle_after",  32'(state_dbg), 32'(ST_IDLE));
    check("rmc_vblank",      32'(in_vblank), 32'd1);
    rd_chk("rmc_lost", REG_HOUR, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
